// File: rtl/tang_sdram_model.sv
`default_nettype none
// ============================================================================
//  Module   : tang_sdram_model
//  Purpose  : Cycle-accurate behavioural SDRAM device model (4 banks, x32,
//             burst length 1, CAS latency 2 or 3) for controller bring-up.
//             Decodes controller commands, keeps per-bank open-row state,
//             stores data in an internal array and returns read data on a
//             per-byte driven bus exactly CL cycles after the READ edge.
//  Option   : define SDRAM_MODEL_CHECK_EN to enable the sticky protocol
//             (err_protocol) and bus-contention (err_conflict) checkers;
//             without it both flags are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module tang_sdram_model #(
    parameter int ROW_BITS = 11,
    parameter int COL_BITS = 8
) (
    input  logic        MainClk,
    input  logic        ResetN,
    input  logic        sdram_CKE,
    input  logic        sdram_CSn,
    input  logic        sdram_RASn,
    input  logic        sdram_CASn,
    input  logic        sdram_WEn,
    input  logic [1:0]  sdram_BA,
    input  logic [10:0] sdram_ADDR,
    input  logic [3:0]  sdram_DQM,
    input  logic [31:0] sdram_DQ_write,
    input  logic [31:0] sdram_DQ_writeEnable,
    output logic [31:0] sdram_DQ_read,
    output logic [3:0]  sdram_DQ_drive,
    output logic        err_protocol,
    output logic        err_conflict
);

    localparam int WORD_BITS = 2 + ROW_BITS + COL_BITS;
    localparam int DEPTH     = 4 * (1 << (ROW_BITS + COL_BITS));

    // {RASn, CASn, WEn} command encodings
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_MRS       = 3'b000;

    // Per-bank state encoding
    localparam logic [0:0] BANK_IDLE   = 1'b0;
    localparam logic [0:0] BANK_ACTIVE = 1'b1;

    // Storage array; never reset so contents survive a ResetN pulse
    logic [31:0]          mem [DEPTH];

    logic [0:0]           bank_state [4];
    logic [ROW_BITS-1:0]  open_row   [4];
    logic                 mode_valid;
    logic [1:0]           cas_latency;

    logic [2:0]           cmd;
    logic                 sel_active;
    logic                 any_active;
    logic [WORD_BITS-1:0] word_idx;
    logic [2:0]           mrs_cl;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 act_ok;
    logic                 mrs_ok;
    logic                 proto_err;
    logic [31:0]          rd_word;

    // Read return pipeline: CL=3 enters at stage 0, CL=2 enters at stage 1,
    // stage 2 feeds the output register so data appears CL edges later.
    logic [2:0]           pipe_valid;
    logic [31:0]          pipe_data [3];
    logic [3:0]           pipe_mask [3];
    logic [31:0]          dq_read_q;
    logic [3:0]           dq_drive_q;

    // A command is only seen when the device is clocked and selected
    always_comb begin
        cmd = CMD_NOP;
        if (sdram_CKE && !sdram_CSn) begin
            cmd = {sdram_RASn, sdram_CASn, sdram_WEn};
        end
    end

    // Legality of the current command and the addressed array word
    always_comb begin
        sel_active = (bank_state[sdram_BA] == BANK_ACTIVE);
        any_active = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (bank_state[b] == BANK_ACTIVE) begin
                any_active = 1'b1;
            end
        end
        word_idx  = {sdram_BA, open_row[sdram_BA], sdram_ADDR[COL_BITS-1:0]};
        mrs_cl    = sdram_ADDR[6:4];
        rd_ok     = (cmd == CMD_READ)   && mode_valid && sel_active;
        wr_ok     = (cmd == CMD_WRITE)  && mode_valid && sel_active;
        act_ok    = (cmd == CMD_ACTIVE) && mode_valid && !sel_active;
        mrs_ok    = (cmd == CMD_MRS) && ((mrs_cl == 3'd2) || (mrs_cl == 3'd3))
                    && (sdram_ADDR[2:0] == 3'b000);
        proto_err = ((cmd == CMD_READ)   && !rd_ok)  ||
                    ((cmd == CMD_WRITE)  && !wr_ok)  ||
                    ((cmd == CMD_ACTIVE) && !act_ok) ||
                    ((cmd == CMD_REFRESH) && any_active) ||
                    ((cmd == CMD_MRS)    && !mrs_ok);
        rd_word   = mem[word_idx];
    end

    // Byte-masked array write in the same cycle as a legal WRITE
    always_ff @(posedge MainClk) begin
        if (wr_ok) begin
            for (int n = 0; n < 4; n++) begin
                if (!sdram_DQM[n]) begin
                    mem[word_idx][8*n +: 8] <= sdram_DQ_write[8*n +: 8];
                end
            end
        end
    end

    // Bank state, open rows and mode register
    always_ff @(posedge MainClk or negedge ResetN) begin
        if (!ResetN) begin
            for (int b = 0; b < 4; b++) begin
                bank_state[b] <= BANK_IDLE;
                open_row[b]   <= '0;
            end
            mode_valid  <= 1'b0;
            cas_latency <= 2'd2;
        end else begin
            case (cmd)
                CMD_ACTIVE: begin
                    if (act_ok) begin
                        bank_state[sdram_BA] <= BANK_ACTIVE;
                        open_row[sdram_BA]   <= sdram_ADDR[ROW_BITS-1:0];
                    end
                end
                CMD_PRECHARGE: begin
                    if (sdram_ADDR[10]) begin
                        for (int b = 0; b < 4; b++) begin
                            bank_state[b] <= BANK_IDLE;
                        end
                    end else begin
                        bank_state[sdram_BA] <= BANK_IDLE;
                    end
                end
                CMD_MRS: begin
                    // An illegal mode word leaves the previous setting intact
                    if (mrs_ok) begin
                        mode_valid  <= 1'b1;
                        cas_latency <= mrs_cl[1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read latency pipeline and registered DQ output
    always_ff @(posedge MainClk or negedge ResetN) begin
        if (!ResetN) begin
            pipe_valid <= '0;
            for (int s = 0; s < 3; s++) begin
                pipe_data[s] <= '0;
                pipe_mask[s] <= '0;
            end
            dq_read_q  <= '0;
            dq_drive_q <= '0;
        end else begin
            pipe_valid[0] <= rd_ok && (cas_latency == 2'd3);
            pipe_data[0]  <= rd_word;
            pipe_mask[0]  <= ~sdram_DQM;

            if (rd_ok && (cas_latency == 2'd2)) begin
                pipe_valid[1] <= 1'b1;
                pipe_data[1]  <= rd_word;
                pipe_mask[1]  <= ~sdram_DQM;
            end else begin
                pipe_valid[1] <= pipe_valid[0];
                pipe_data[1]  <= pipe_data[0];
                pipe_mask[1]  <= pipe_mask[0];
            end

            pipe_valid[2] <= pipe_valid[1];
            pipe_data[2]  <= pipe_data[1];
            pipe_mask[2]  <= pipe_mask[1];

            dq_read_q  <= pipe_valid[2] ? pipe_data[2] : 32'h0;
            dq_drive_q <= pipe_valid[2] ? pipe_mask[2] : 4'h0;
        end
    end

    assign sdram_DQ_read  = dq_read_q;
    assign sdram_DQ_drive = dq_drive_q;

`ifdef SDRAM_MODEL_CHECK_EN
    logic [3:0] byte_contend;
    logic       err_protocol_q;
    logic       err_conflict_q;

    // A byte is contended when both the model and the controller drive it
    always_comb begin
        byte_contend = '0;
        for (int n = 0; n < 4; n++) begin
            byte_contend[n] = dq_drive_q[n] && (|sdram_DQ_writeEnable[8*n +: 8]);
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge MainClk or negedge ResetN) begin
        if (!ResetN) begin
            err_protocol_q <= 1'b0;
            err_conflict_q <= 1'b0;
        end else begin
            if (proto_err) begin
                err_protocol_q <= 1'b1;
            end
            if (|byte_contend) begin
                err_conflict_q <= 1'b1;
            end
        end
    end

    assign err_protocol = err_protocol_q;
    assign err_conflict = err_conflict_q;
`else
    logic unused_check_inputs;
    assign unused_check_inputs = ^{proto_err, sdram_DQ_writeEnable};
    assign err_protocol = 1'b0;
    assign err_conflict = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tang_sdram_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tang_sdram_model
//  Purpose  : Scoreboard bench for tang_sdram_model: stimulus tasks update a
//             behavioural model and queue expected read returns; a monitor
//             on the falling edge pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tang_sdram_model;

    logic        clk;
    logic        rst_n;
    logic        cke;
    logic        csn;
    logic        rasn;
    logic        casn;
    logic        wen;
    logic [1:0]  ba;
    logic [10:0] addr;
    logic [3:0]  dqm;
    logic [31:0] dq_w;
    logic [31:0] dq_we;
    logic [31:0] dq_r;
    logic [3:0]  dq_drive;
    logic        err_p;
    logic        err_c;

    tang_sdram_model dut (
        .MainClk              (clk),
        .ResetN               (rst_n),
        .sdram_CKE            (cke),
        .sdram_CSn            (csn),
        .sdram_RASn           (rasn),
        .sdram_CASn           (casn),
        .sdram_WEn            (wen),
        .sdram_BA             (ba),
        .sdram_ADDR           (addr),
        .sdram_DQM            (dqm),
        .sdram_DQ_write       (dq_w),
        .sdram_DQ_writeEnable (dq_we),
        .sdram_DQ_read        (dq_r),
        .sdram_DQ_drive       (dq_drive),
        .err_protocol         (err_p),
        .err_conflict         (err_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Edge counter: after edge e, cyc == e
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
        logic [3:0]  known;
        logic [3:0]  drive;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem   [int];
    logic [3:0]  m_known [int];
    bit          m_act [4];
    int          m_row [4];
    bit          m_mv;
    int          m_cl;
    bit          exp_perr;
    bit          exp_cerr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic want(input bit v);
`ifdef SDRAM_MODEL_CHECK_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input int b, input int row, input int col);
        return (b << 19) | (row << 8) | (col & 255);
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_act[b] = 1'b0;
            m_row[b] = 0;
        end
        m_mv     = 1'b0;
        m_cl     = 2;
        exp_perr = 1'b0;
        exp_cerr = 1'b0;
        sb.delete();
    endtask

    // Applies one decoded command to the model (called just after its edge)
    task automatic model_cmd(input logic [2:0] c, input int b, input logic [10:0] a,
                             input logic [3:0] m, input logic [31:0] d);
        int          k;
        logic [31:0] w;
        logic [3:0]  kn;
        exp_t        e;
        bit          any;
        case (c)
            3'b011: begin
                if (!m_mv || m_act[b]) exp_perr = 1'b1;
                else begin
                    m_act[b] = 1'b1;
                    m_row[b] = int'(a);
                end
            end
            3'b101, 3'b100: begin
                if (!m_mv || !m_act[b]) exp_perr = 1'b1;
                else begin
                    k  = widx(b, m_row[b], int'(a[7:0]));
                    w  = m_mem.exists(k) ? m_mem[k] : 32'h0;
                    kn = m_known.exists(k) ? m_known[k] : 4'h0;
                    if (c == 3'b100) begin
                        for (int n = 0; n < 4; n++) begin
                            if (!m[n]) begin
                                w[8*n +: 8] = d[8*n +: 8];
                                kn[n] = 1'b1;
                            end
                        end
                        m_mem[k]   = w;
                        m_known[k] = kn;
                    end else begin
                        e.due   = cyc + m_cl;
                        e.data  = w;
                        e.known = kn;
                        e.drive = ~m;
                        sb.push_back(e);
                    end
                end
            end
            3'b010: begin
                if (a[10]) for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
                else m_act[b] = 1'b0;
            end
            3'b001: begin
                any = 1'b0;
                for (int i = 0; i < 4; i++) if (m_act[i]) any = 1'b1;
                if (any) exp_perr = 1'b1;
            end
            3'b000: begin
                if ((a[6:4] == 3'd2 || a[6:4] == 3'd3) && a[2:0] == 3'd0) begin
                    m_mv = 1'b1;
                    m_cl = int'(a[6:4]);
                end else begin
                    exp_perr = 1'b1;
                end
            end
            default: begin
            end
        endcase
    endtask

    // ---------------- stimulus tasks ----------------
    task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [10:0] a,
                       input logic [3:0] m, input logic [31:0] d, input logic ke, input logic cs);
        cke = ke; csn = cs; {rasn, casn, wen} = c;
        ba = b; addr = a; dqm = m; dq_w = d;
        @(posedge clk);
        #1;
        if (ke && !cs) model_cmd(c, int'(b), a, m, d);
        cke = 1'b1; csn = 1'b0; {rasn, casn, wen} = 3'b111;
        ba = 2'd0; addr = 11'd0; dqm = 4'h0; dq_w = 32'h0;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cmd(3'b111, 2'd0, 11'd0, 4'h0, 32'h0, 1'b1, 1'b0);
    endtask
    task automatic mrs(input logic [10:0] a);
        cmd(3'b000, 2'd0, a, 4'h0, 32'h0, 1'b1, 1'b0);
    endtask
    task automatic act(input logic [1:0] b, input logic [10:0] row);
        cmd(3'b011, b, row, 4'h0, 32'h0, 1'b1, 1'b0);
    endtask
    task automatic rd(input logic [1:0] b, input logic [10:0] col, input logic [3:0] m);
        cmd(3'b101, b, col, m, 32'h0, 1'b1, 1'b0);
    endtask
    task automatic wr(input logic [1:0] b, input logic [10:0] col, input logic [31:0] d, input logic [3:0] m);
        cmd(3'b100, b, col, m, d, 1'b1, 1'b0);
    endtask
    task automatic pre(input logic [1:0] b, input logic all);
        cmd(3'b010, b, {all, 10'd0}, 4'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dq_read"}, dq_r, 32'h0);
        chk({tag, "_dq_drive"}, {28'h0, dq_drive}, 32'h0);
        chk({tag, "_err_protocol"}, {31'h0, err_p}, 32'h0);
        chk({tag, "_err_conflict"}, {31'h0, err_c}, 32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_missing: no read return seen at cycle %0d (now %0d)", sb[0].due, cyc);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                logic [31:0] mk;
                for (int n = 0; n < 4; n++) mk[8*n +: 8] = {8{sb[0].known[n]}};
                chk("rd_drive", {28'h0, dq_drive}, {28'h0, sb[0].drive});
                chk("rd_data", dq_r & mk, sb[0].data & mk);
                void'(sb.pop_front());
            end else if (dq_drive !== 4'h0 || dq_r !== 32'h0) begin
                checks++;
                errors++;
                $display("FAIL idle_bus: got drive=%h data=%h expected 0 (cycle %0d)", dq_drive, dq_r, cyc);
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; cke = 1'b1; csn = 1'b0; {rasn, casn, wen} = 3'b111;
        ba = 2'd0; addr = 11'd0; dqm = 4'h0; dq_w = 32'h0; dq_we = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("init");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        nop(2);

        // Basic write then read at CL=2
        mrs(11'h020);
        act(2'd1, 11'h005);
        wr(2'd1, 11'h010, 32'hDEADBEEF, 4'h0);
        rd(2'd1, 11'h010, 4'h0);
        nop(4);

        // CL=3 with byte-masked overwrite issued on consecutive cycles
        mrs(11'h030);
        wr(2'd1, 11'h020, 32'h11223344, 4'h0);
        wr(2'd1, 11'h020, 32'hAABBCCDD, 4'h5);
        rd(2'd1, 11'h020, 4'h0);
        nop(5);

        // Back-to-back reads at CL=2
        mrs(11'h020);
        for (int i = 0; i < 4; i++) wr(2'd1, 11'(i), $urandom, 4'h0);
        for (int i = 0; i < 4; i++) rd(2'd1, 11'(i), 4'h0);
        nop(4);

        // Controller drives byte 0 during a read return
        rd(2'd1, 11'h010, 4'h0);
        nop(2);
        dq_we = 32'h0000_00FF;
        nop(1);
        dq_we = 32'h0;
        exp_cerr = 1'b1;
        chk("err_conflict", {31'h0, err_c}, {31'h0, want(exp_cerr)});
        nop(2);

        // READ to an idle bank: flag only, nothing driven
        rd(2'd2, 11'h000, 4'h0);
        chk("err_protocol_set", {31'h0, err_p}, {31'h0, want(exp_perr)});
        nop(3);
        chk("err_protocol_sticky", {31'h0, err_p}, {31'h0, want(exp_perr)});
        chk("err_conflict_sticky", {31'h0, err_c}, {31'h0, want(exp_cerr)});

        // Reset one cycle after a CL=3 read drops the return
        mrs(11'h030);
        rd(2'd1, 11'h010, 4'h0);
        nop(1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        nop(5);
        mrs(11'h020);
        act(2'd1, 11'h005);
        rd(2'd1, 11'h010, 4'h0);
        nop(3);

        // Illegal MRS (CL=1) flags and keeps CL=2
        mrs(11'h010);
        chk("err_protocol_mrs", {31'h0, err_p}, {31'h0, want(exp_perr)});
        rd(2'd1, 11'h010, 4'h0);
        rd(2'd1, 11'h020, 4'h3);
        nop(4);

        // Randomized legal traffic
        for (int i = 0; i < 400; i++) begin
            int b;
            int r;
            bit any;
            b = $urandom_range(0, 3);
            r = $urandom_range(0, 99);
            any = 1'b0;
            for (int j = 0; j < 4; j++) if (m_act[j]) any = 1'b1;
            if (r < 3) begin
                nop(4);
                mrs($urandom_range(0, 1) ? 11'h020 : 11'h030);
            end else if (r < 8) begin
                logic ke;
                ke = 1'(($urandom_range(0, 1)));
                cmd(3'($urandom_range(0, 7)), 2'(b), 11'($urandom_range(0, 2047)),
                    4'($urandom_range(0, 15)), $urandom, ke, ke ? 1'b1 : 1'(($urandom_range(0, 1))));
            end else if (r < 14) begin
                pre(2'(b), 1'(($urandom_range(0, 3) == 0)));
            end else if (r < 17) begin
                if (!any) cmd(3'b001, 2'd0, 11'd0, 4'h0, 32'h0, 1'b1, 1'b0);
                else nop(1);
            end else if (!m_act[b]) begin
                act(2'(b), 11'($urandom_range(0, 3)));
            end else if (r < 55) begin
                wr(2'(b), 11'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
            end else begin
                rd(2'(b), 11'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            end
        end
        nop(6);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("final_err_protocol", {31'h0, err_p}, {31'h0, want(exp_perr)});
        chk("final_err_conflict", {31'h0, err_c}, {31'h0, want(exp_cerr)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tang_sdram_model.md
TANG_SDRAM_MODEL -- requirements
Module: tang_sdram_model

Interface
REQ-001 SHALL have parameter ROW_BITS, default 11, number of row-address bits stored (upper row bits alias).
REQ-002 SHALL have parameter COL_BITS, default 8, column bits taken from ADDR[COL_BITS-1:0].
REQ-003 SHALL have ports, one per line (name, direction, width, meaning), clock and reset first:
- MainClk, in, 1, single clock; all logic on rising edge.
- ResetN, in, 1, asynchronous active-low reset.
- sdram_CKE, in, 1, clock enable.
- sdram_CSn, in, 1, chip select, active low.
- sdram_RASn / sdram_CASn / sdram_WEn, in, 1 each, command strobes.
- sdram_BA, in, 2, bank address.
- sdram_ADDR, in, 11, row/column/mode address; ADDR[10] = all-banks flag on PRECHARGE.
- sdram_DQM, in, 4, byte mask, bit n covers DQ[8n+7:8n].
- sdram_DQ_write, in, 32, controller write data.
- sdram_DQ_writeEnable, in, 32, controller per-bit drive enable.
- sdram_DQ_read, out, 32, model read data.
- sdram_DQ_drive, out, 4, model per-byte drive enable.
- err_protocol, out, 1, sticky protocol-violation flag.
- err_conflict, out, 1, sticky bus-contention flag.

Function
REQ-004 SHALL decode a command only when CKE=1 and CSn=0; otherwise the cycle is NOP.
REQ-005 SHALL decode {RASn,CASn,WEn}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 MODE REGISTER SET, 110 BURST TERMINATE (treated as NOP).
REQ-006 SHALL keep per bank a state IDLE/ACTIVE and an open-row register; ACTIVE moves IDLE->ACTIVE and latches ADDR[ROW_BITS-1:0]; PRECHARGE moves the addressed bank (all banks if ADDR[10]=1) to IDLE; precharging an IDLE bank is legal.
REQ-007 SHALL on MRS latch CAS latency from ADDR[6:4]; only 2 and 3 are legal; burst length ADDR[2:0] SHALL be 000 (BL1); mode_valid set on a legal MRS.
REQ-008 SHALL map word index = {BA, open_row, ADDR[COL_BITS-1:0]}; array depth 4*2^(ROW_BITS+COL_BITS) x 32.
REQ-009 SHALL on WRITE to an ACTIVE bank store DQ_write in the same cycle, updating only bytes whose DQM bit is 0.
REQ-010 SHALL on READ to an ACTIVE bank present the word on sdram_DQ_read exactly CL cycles after the READ edge, for one cycle, with sdram_DQ_drive = ~DQM sampled at the READ edge; otherwise DQ_drive = 0 and DQ_read = 0.
REQ-011 SHALL accept a READ every cycle (pipeline depth 3); back-to-back reads return back-to-back.
REQ-012 SHALL return in a read the data written by a WRITE to the same address issued on an earlier cycle, including the immediately preceding cycle.
REQ-013 SHALL flag err_protocol on: READ/WRITE to IDLE bank, ACTIVE to ACTIVE bank, AUTO REFRESH with any bank ACTIVE, READ/WRITE/ACTIVE before mode_valid, illegal MRS fields; offending READ/WRITE SHALL not access the array, and a bad READ drives nothing.
REQ-014 SHALL flag err_conflict in any cycle where DQ_drive byte n=1 and any DQ_writeEnable bit of byte n is 1.
REQ-015 SHALL treat AUTO REFRESH with all banks IDLE as a no-op on state and data.
REQ-016 Error flags SHALL be sticky until reset.

Reset
REQ-017 SHALL on ResetN=0 immediately: all banks IDLE, open rows 0, mode_valid=0, CL=2, read pipeline flushed, DQ_read=0, DQ_drive=0, err flags 0.
REQ-018 SHALL drop in-flight reads on reset mid-operation; array contents SHALL not be cleared.

Configuration
REQ-019 SHALL with SDRAM_MODEL_CHECK_EN defined implement REQ-013/014 checks; without it err_protocol and err_conflict are constant 0, illegal commands still skip array access, illegal MRS leaves CL unchanged.

Verification
REQ-020 MRS ADDR=0x020, ACTIVE BA=1 row 0x005, WRITE col 0x10 data 0xDEADBEEF DQM=0, READ col 0x10 -> DQ_read=0xDEADBEEF, DQ_drive=0xF exactly 2 cycles after READ.
REQ-021 MRS CL=3, WRITE 0x11223344 then WRITE 0xAABBCCDD DQM=0x5 same address, READ -> 0xAA22CC44 3 cycles after READ.
REQ-022 Four consecutive READs cols 0..3 at CL=2 -> four consecutive drive cycles, data in order, no gaps.
REQ-023 READ to IDLE bank 2 -> err_protocol=1 next cycle, DQ_drive stays 0; stays 1 until ResetN pulse.
REQ-024 Controller asserts DQ_writeEnable=0x000000FF on the cycle model drives read data -> err_conflict=1.
REQ-025 ResetN low one cycle after READ at CL=3 -> no drive cycle follows; after re-MRS, prior written data still readable.
